// File: rtl/jkff_stim_if.sv
// J/K stimulus bundle between the stimulus driver and its environment.
// The master side is the driver. It issues J/K and reports its model and status.
// The slave side is the environment. It supplies start, pattern and the fed-back Q.
interface jkff_stim_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             q_obs;
  logic             J;
  logic             K;
  logic             q_model;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CW-1:0]    err_count;

  modport master (
    input  start, pattern, q_obs,
    output J, K, q_model, busy, done, mismatch, err_count
  );

  modport slave (
    output start, pattern, q_obs,
    input  J, K, q_model, busy, done, mismatch, err_count
  );
endinterface

// File: rtl/jkff_stim_driver.sv
// Drives a downstream JK flop so that its Q follows a WIDTH-bit target pattern,
// one bit per clock with the LSB first. Each cycle, the fed-back Q is checked
// against an internal model of what the flop should hold.
module jkff_stim_driver #(
  parameter int WIDTH      = 8,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  jkff_stim_if.master    bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             q_model_r;
  logic             mismatch_r;
  logic [CW-1:0]    err_r;
  logic             cmp_fail;

  // Compare the flop's Q against the model in every DRIVE cycle and in CHECK.
  assign cmp_fail = ((state == S_DRIVE) || (state == S_CHECK)) &&
                    (bus.q_obs != q_model_r);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: PRIME, then WIDTH DRIVE cycles, then CHECK and DONE.
  always_comb begin
    // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_DRIVE;
      S_DRIVE: if (idx == IW'(WIDTH - 1)) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pattern shift register, bit index, flop model and error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is plain flops, not a memory array, so it is reset along with the rest.
      shreg      <= '0;
      idx        <= '0;
      q_model_r  <= 1'b0;
      mismatch_r <= 1'b0;
      err_r      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            shreg      <= bus.pattern;
            idx        <= '0;
            mismatch_r <= 1'b0;
            err_r      <= '0;
          end
        end
        S_PRIME: q_model_r <= 1'b0;
        S_DRIVE: begin
          q_model_r <= shreg[0];
          shreg     <= {1'b0, shreg[WIDTH-1:1]};
          idx       <= idx + IW'(1);
        end
        default: ;
      endcase

      if (cmp_fail) begin
        mismatch_r <= 1'b1;
        if (err_r != '1) err_r <= err_r + CW'(1);
      end
    end
  end

  // Output decode: J/K and status come only from registered state.
  always_comb begin
    bus.J    = 1'b0;
    bus.K    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      S_PRIME: begin
        bus.K    = 1'b1;
        bus.busy = 1'b1;
      end
      S_DRIVE: begin
        bus.busy = 1'b1;
        if (shreg[0] != q_model_r) begin
          if (USE_TOGGLE) begin
            bus.J = 1'b1;
            bus.K = 1'b1;
          end else begin
            bus.J = shreg[0];
            bus.K = ~shreg[0];
          end
        end
      end
      S_CHECK: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.q_model   = q_model_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.err_count = err_r;

endmodule

// File: tb/tb_jkff_stim_driver.sv
// Self-checking bench for jkff_stim_driver. A set/reset instance and a toggle
// instance run side by side. Each one loops back through its own ideal JK flop.
module tb_jkff_stim_driver;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic         tie0;
  logic         glitch;
  logic         q_ff0 = 1'b0;
  logic         q_ff1 = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  jkff_stim_if #(.WIDTH(W)) bus0 ();
  jkff_stim_if #(.WIDTH(W)) bus1 ();

  assign bus0.start   = start;
  assign bus0.pattern = pattern;
  assign bus0.q_obs   = tie0 ? 1'b0 : (glitch ? 1'b1 : q_ff0);
  assign bus1.start   = start;
  assign bus1.pattern = pattern;
  assign bus1.q_obs   = q_ff1;

  jkff_stim_driver #(.WIDTH(W), .USE_TOGGLE(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  jkff_stim_driver #(.WIDTH(W), .USE_TOGGLE(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal JK flops fed by each driver.
  always @(posedge clk) begin
    case ({bus0.J, bus0.K})
      2'b01:   q_ff0 <= 1'b0;
      2'b10:   q_ff0 <= 1'b1;
      2'b11:   q_ff0 <= ~q_ff0;
      default: ;
    endcase
    case ({bus1.J, bus1.K})
      2'b01:   q_ff1 <= 1'b0;
      2'b10:   q_ff1 <= 1'b1;
      2'b11:   q_ff1 <= ~q_ff1;
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0] jk0;
    logic [1:0] jk1;
    logic       qm;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until done is seen or the bound expires, and returns the cycles taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus0.done && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;

    // PRIME, DRIVE0..7, CHECK, DONE for pattern 8'b10110010.
    vecs[0]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 2'b11, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 2'b11, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1};

    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    tie0    = 1'b0;
    glitch  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_outs", {bus0.J, bus0.K, bus0.q_model, bus0.busy, bus0.done, bus0.mismatch}, 6'b0);
    check("rst_err", 32'(bus0.err_count), 32'd0);
    reset = 1'b0;
    step();

    // Ideal run, both excitation styles
    pattern = 8'b10110010;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("vec%0d_setrst", i),
            {bus0.J, bus0.K, bus0.q_model, bus0.busy, bus0.done},
            {vecs[i].jk0, vecs[i].qm, vecs[i].busy, vecs[i].done});
      check($sformatf("vec%0d_toggle", i),
            {bus1.J, bus1.K, bus1.q_model, bus1.busy, bus1.done},
            {vecs[i].jk1, vecs[i].qm, vecs[i].busy, vecs[i].done});
      step();
    end
    check("ideal_err0", {28'(bus0.err_count), 3'b0, bus0.mismatch}, 32'd0);
    check("ideal_err1", {28'(bus1.err_count), 3'b0, bus1.mismatch}, 32'd0);
    check("ideal_qm_hold", 32'(bus0.q_model), 32'd1);

    // All-ones pattern with Q stuck at 0. Start stays high for the whole run.
    pattern = 8'hFF;
    tie0    = 1'b1;
    start   = 1'b1;
    step();                                     // PRIME
    step();                                     // DRIVE0
    step();                                     // DRIVE1
    check("stuck_mm_d1", 32'(bus0.mismatch), 32'd0);
    step();                                     // DRIVE2
    check("stuck_mm_d2", 32'(bus0.mismatch), 32'd1);
    check("stuck_err_d2", 32'(bus0.err_count), 32'd1);
    repeat (7) step();                          // DONE
    check("stuck_done", 32'(bus0.done), 32'd1);
    check("stuck_err", 32'(bus0.err_count), 32'd8);
    check("stuck_mm", 32'(bus0.mismatch), 32'd1);
    step();                                     // IDLE, start is still high
    check("held_idle", {bus0.done, bus0.busy}, 2'b00);
    check("held_err_hold", 32'(bus0.err_count), 32'd8);
    step();                                     // PRIME of the second run
    check("held_restart", {bus0.busy, bus0.J, bus0.K}, 3'b101);
    check("held_clear", {28'(bus0.err_count), 3'b0, bus0.mismatch}, 32'd0);
    start = 1'b0;
    tie0  = 1'b0;
    wait_done(n);
    check("held_latency", 32'(n), 32'd10);
    check("held_run_err", 32'(bus0.err_count), 32'd0);
    step();

    // Reset in DRIVE3 of a failing run
    pattern = 8'hFF;
    tie0    = 1'b1;
    start   = 1'b1;
    step();                                     // PRIME
    start = 1'b0;
    repeat (4) step();                          // DRIVE3
    check("pre_rst_err", 32'(bus0.err_count), 32'd2);
    check("pre_rst_qm", 32'(bus0.q_model), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_outs", {bus0.J, bus0.K, bus0.q_model, bus0.busy, bus0.done, bus0.mismatch}, 6'b0);
    check("mid_rst_err", 32'(bus0.err_count), 32'd0);
    reset  = 1'b0;
    tie0   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus0.done || bus0.busy) pulses++;
      step();
    end
    check("mid_rst_quiet", 32'(pulses), 32'd0);
    pattern = 8'b10110010;
    start   = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("post_rst_latency", 32'(n), 32'd10);
    check("post_rst_err", 32'(bus0.err_count), 32'd0);
    check("post_rst_qm", 32'(bus0.q_model), 32'd1);
    step();
    check("done_one_cycle", 32'(bus0.done), 32'd0);

    // Single glitch on Q in DRIVE5 of an all-zero pattern
    pattern = 8'h00;
    start   = 1'b1;
    step();                                     // PRIME
    start = 1'b0;
    for (int d = 0; d < 8; d++) begin
      step();                                   // DRIVE d
      glitch = (d == 5);
      check($sformatf("zero_jk_d%0d", d), {bus0.J, bus0.K}, 2'b00);
    end
    glitch = 1'b0;
    step();                                     // CHECK
    step();                                     // DONE
    check("glitch_done", 32'(bus0.done), 32'd1);
    check("glitch_err", 32'(bus0.err_count), 32'd1);
    check("glitch_mm", 32'(bus0.mismatch), 32'd1);
    check("glitch_width", 32'(CW), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
